walking_bit_burst_ctrl: RTL and testbench
=========================================

# walking_bit_burst_ctrl

Sequencer for the walking-bit test-pattern generator on the FT601 transmit path. It schedules bursts of generator words toward the FT601 TX FIFO with a valid/ready handshake. It advances the generator only on accepted beats, marks the last beat of each burst, and inserts programmable idle gaps between bursts. Host-side firmware uses it to run repeatable throughput and bit-integrity tests across the USB link.

## Interface
- LEN_WIDTH, 16, width of burst length (beats per burst)
- GAP_WIDTH, 8, width of inter-burst idle count
- CNT_WIDTH, 8, width of burst-count config and status

- i_clk  in  1  single clock; all logic rising-edge
- i_rst_n  in  1  synchronous, active-low reset
- i_start  in  1  start pulse; honoured only in IDLE
- i_abort  in  1  stop request; level or pulse
- i_burst_len  in  LEN_WIDTH  beats per burst; latched on accepted start
- i_num_bursts  in  CNT_WIDTH  bursts to run; 0 = continuous until abort; latched on start
- i_gap  in  GAP_WIDTH  idle cycles between bursts; latched on start
- i_tx_ready  in  1  downstream accepts beat this cycle
- o_tx_valid  out  1  beat presented (generator word is the data)
- o_tx_last  out  1  final beat of current burst, qualified by o_tx_valid
- o_gen_enable  out  1  drives generator i_enable; = o_tx_valid & i_tx_ready (combinational)
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse at run end
- o_beat_count  out  LEN_WIDTH+CNT_WIDTH  beats accepted since last start, wraps
- o_burst_count  out  CNT_WIDTH  bursts completed since last start, wraps

## Operation
- States: IDLE, BURST, GAP, DONE.
- IDLE:
  - i_start=1 with i_burst_len!=0: latch config, clear both counters, go to BURST.
  - i_start with i_burst_len==0: ignored; no o_done.
- BURST:
  - o_tx_valid=1 for the whole state.
  - Beat accepted when o_tx_valid & i_tx_ready. Each accepted beat increments the beat index and o_beat_count.
  - o_tx_last=1 while beat index == latched len-1.
  - On the accepted last beat: increment o_burst_count and clear the beat index. Then:
    - abort pending, or (num_bursts!=0 and completed == num_bursts): go to DONE.
    - else if latched gap==0: stay in BURST; valid stays high, no bubble.
    - else: go to GAP.
- GAP:
  - o_tx_valid=0. Load a down-counter with gap on entry.
  - Go to BURST after exactly gap cycles in GAP.
  - Abort seen in GAP: go to DONE next cycle.
- DONE: o_done=1 for one cycle, then IDLE.
- Abort handling:
  - i_abort during BURST sets a sticky abort_pending flag. The current burst completes normally with o_tx_last. No beat is dropped and valid is never retracted before ready.
  - abort_pending clears on entry to IDLE.
  - i_abort in IDLE has no effect.
- Handshake rule: once o_tx_valid rises it stays high until a beat is accepted. o_tx_last is stable while valid is held.
- Generator advances only through o_gen_enable, so the word sequence seen downstream is gap-free across stalls and bursts. The generator is not reset by this block.
- i_start while busy is ignored. Config inputs are sampled only on an accepted start.
- Counters wrap modulo 2^width; no saturation. The completion compare uses the wrapped o_burst_count.

## Timing
- Reset (i_rst_n=0 at a rising edge) puts these values on the next cycle:
  - state IDLE
  - o_tx_valid=0, o_tx_last=0, o_gen_enable=0
  - o_busy=0, o_done=0
  - o_beat_count=0, o_burst_count=0
  - abort_pending=0
- Reset mid-burst drops valid immediately; this is the only case where valid falls without a handshake.
- Start latency: i_start at edge N gives o_tx_valid=1 and o_busy=1 from cycle N+1.
- With i_tx_ready held high:
  - burst of L beats occupies L cycles
  - gap G gives exactly G cycles of valid=0 between bursts
  - run end: o_done high the cycle after the final accepted beat; o_busy falls one cycle later
- o_gen_enable has zero latency vs the handshake, so generator state moves at the same edge the beat is accepted.
- Simultaneous abort and accepted last beat: go to DONE; that burst counts as completed.
- Simultaneous start and abort in IDLE: start accepted, abort ignored.

## Test plan
- Single burst, ready always 1, len=4, num=1, gap=0:
  - 4 valid cycles; last on the 4th; generator enabled 4 cycles
  - done pulse the next cycle; beat_count=4, burst_count=1
- Back-pressure, len=3, num=2, gap=2, ready toggling 1,0,1,0…:
  - valid never drops while ready=0; last asserted on beats 3 and 6
  - exactly 2 idle cycles between bursts; enable count = 6
- Continuous mode, num=0, len=2, gap=0:
  - valid held high indefinitely; last on every 2nd beat
  - i_abort mid-burst: burst finishes, then done; burst_count reflects completed bursts
- Abort during GAP, gap=5: DONE the next cycle, no further valid, burst_count unchanged.
- Edge config:
  - len=0 start: no activity, no done
  - start while busy: ignored
  - counters wrap: CNT_WIDTH=2, num=0, run 5 bursts gives burst_count=1
- Reset asserted mid-burst with valid high:
  - all outputs zero the next cycle
  - a subsequent start runs cleanly with counters from 0

Source files
------------

// File: rtl/walking_bit_burst_ctrl.sv
// Burst sequencer for the walking-bit pattern generator on the FT601 TX path.
// It presents bursts of generator words over a valid/ready handshake, marks
// the final beat of each burst, and inserts programmable idle gaps between
// bursts. The generator advances only on accepted beats.
//
// Handshake: a beat transfers on any rising edge where o_tx_valid and
// i_tx_ready are both high. Once o_tx_valid rises it stays high, with
// o_tx_last stable, until a beat transfers. Reset is the only exception.
module walking_bit_burst_ctrl #(
  parameter int LEN_WIDTH = 16,
  parameter int GAP_WIDTH = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic                           i_abort,
  input  logic [LEN_WIDTH-1:0]           i_burst_len,
  input  logic [CNT_WIDTH-1:0]           i_num_bursts,
  input  logic [GAP_WIDTH-1:0]           i_gap,
  input  logic                           i_tx_ready,
  output logic                           o_tx_valid,
  output logic                           o_tx_last,
  output logic                           o_gen_enable,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [LEN_WIDTH+CNT_WIDTH-1:0] o_beat_count,
  output logic [CNT_WIDTH-1:0]           o_burst_count,
  output logic [1:0]                     o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LEN_WIDTH-1:0]           LEN_ONE  = 1;
  localparam logic [GAP_WIDTH-1:0]           GAP_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0]           CNT_ONE  = 1;
  localparam logic [LEN_WIDTH+CNT_WIDTH-1:0] BEAT_ONE = 1;

  state_t                         state_q, state_d;
  logic [LEN_WIDTH-1:0]           len_q, len_d;
  logic [CNT_WIDTH-1:0]           num_q, num_d;
  logic [GAP_WIDTH-1:0]           gap_q, gap_d;
  logic [GAP_WIDTH-1:0]           gap_cnt_q, gap_cnt_d;
  logic [LEN_WIDTH-1:0]           beat_idx_q, beat_idx_d;
  logic [LEN_WIDTH+CNT_WIDTH-1:0] beat_count_q, beat_count_d;
  logic [CNT_WIDTH-1:0]           burst_count_q, burst_count_d;
  logic                           abort_pending_q, abort_pending_d;

  logic                           tx_valid;
  logic                           is_last;
  logic                           beat_acc;
  logic                           abort_now;
  logic [CNT_WIDTH-1:0]           burst_next;

  assign tx_valid   = (state_q == S_BURST);
  assign is_last    = (beat_idx_q == (len_q - LEN_ONE));
  assign beat_acc   = tx_valid & i_tx_ready;
  assign abort_now  = abort_pending_q | i_abort;
  assign burst_next = burst_count_q + CNT_ONE;

  assign o_tx_valid    = tx_valid;
  assign o_tx_last     = tx_valid & is_last;
  assign o_gen_enable  = beat_acc;
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = (state_q == S_DONE);
  assign o_beat_count  = beat_count_q;
  assign o_burst_count = burst_count_q;
  assign o_dbg_state   = state_q;

  // Next-state, config latch, counters and abort tracking.
  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    num_d           = num_q;
    gap_d           = gap_q;
    gap_cnt_d       = gap_cnt_q;
    beat_idx_d      = beat_idx_q;
    beat_count_d    = beat_count_q;
    burst_count_d   = burst_count_q;
    abort_pending_d = abort_pending_q;
    case (state_q)
      S_IDLE: begin
        abort_pending_d = 1'b0;
        // A zero-length start is ignored entirely; abort has no effect here.
        if (i_start && (i_burst_len != '0)) begin
          len_d         = i_burst_len;
          num_d         = i_num_bursts;
          gap_d         = i_gap;
          beat_idx_d    = '0;
          beat_count_d  = '0;
          burst_count_d = '0;
          state_d       = S_BURST;
        end
      end
      S_BURST: begin
        // Abort only ends the run at a burst boundary, so remember it.
        abort_pending_d = abort_now;
        if (beat_acc) begin
          beat_count_d = beat_count_q + BEAT_ONE;
          if (is_last) begin
            burst_count_d = burst_next;
            beat_idx_d    = '0;
            if (abort_now || ((num_q != '0) && (burst_next == num_q))) begin
              state_d = S_DONE;
            end else if (gap_q != '0) begin
              gap_cnt_d = gap_q;
              state_d   = S_GAP;
            end
          end else begin
            beat_idx_d = beat_idx_q + LEN_ONE;
          end
        end
      end
      S_GAP: begin
        if (i_abort) begin
          state_d = S_DONE;
        end else if (gap_cnt_q <= GAP_ONE) begin
          state_d = S_BURST;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end
      S_DONE: begin
        abort_pending_d = 1'b0;
        state_d         = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q         <= S_IDLE;
      len_q           <= '0;
      num_q           <= '0;
      gap_q           <= '0;
      gap_cnt_q       <= '0;
      beat_idx_q      <= '0;
      beat_count_q    <= '0;
      burst_count_q   <= '0;
      abort_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      num_q           <= num_d;
      gap_q           <= gap_d;
      gap_cnt_q       <= gap_cnt_d;
      beat_idx_q      <= beat_idx_d;
      beat_count_q    <= beat_count_d;
      burst_count_q   <= burst_count_d;
      abort_pending_q <= abort_pending_d;
    end
  end

endmodule

// File: tb/tb_walking_bit_burst_ctrl.sv
// Directed bench for walking_bit_burst_ctrl. Expected tx_last flags are queued
// per beat when a run is started and popped by the monitor on each accepted
// beat. CNT_WIDTH is 2 so that burst counter wrap is reachable.
module tb_walking_bit_burst_ctrl;

  localparam int LW = 16;
  localparam int GW = 8;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [LW-1:0] burst_len;
  logic [CW-1:0] num_bursts;
  logic [GW-1:0] gap;
  logic          tx_ready;
  logic          o_tx_valid;
  logic          o_tx_last;
  logic          o_gen_enable;
  logic          o_busy;
  logic          o_done;
  logic [LW+CW-1:0] o_beat_count;
  logic [CW-1:0]    o_burst_count;
  logic [1:0]       o_dbg_state;

  int n_chk  = 0;
  int n_fail = 0;
  int enb_cnt = 0;
  logic [0:0] exp_q[$];
  logic hold_prev = 1'b0;
  logic last_prev = 1'b0;

  walking_bit_burst_ctrl #(.LEN_WIDTH(LW), .GAP_WIDTH(GW), .CNT_WIDTH(CW)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_abort       (abort),
    .i_burst_len   (burst_len),
    .i_num_bursts  (num_bursts),
    .i_gap         (gap),
    .i_tx_ready    (tx_ready),
    .o_tx_valid    (o_tx_valid),
    .o_tx_last     (o_tx_last),
    .o_gen_enable  (o_gen_enable),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_beat_count  (o_beat_count),
    .o_burst_count (o_burst_count),
    .o_dbg_state   (o_dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bursts(input int len, input int n);
    for (int b = 0; b < n; b++)
      for (int i = 0; i < len; i++)
        exp_q.push_back((i == len - 1) ? 1'b1 : 1'b0);
  endtask

  task automatic start_run(input int len, input int num, input int g);
    burst_len  = LW'(len);
    num_bursts = CW'(num);
    gap        = GW'(g);
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic run_until_done(input bit toggle, input int max_cyc,
                                output int valid_cyc, output int gap_cyc);
    valid_cyc = 0;
    gap_cyc   = 0;
    for (int i = 0; i < max_cyc && !o_done; i++) begin
      if (o_tx_valid) valid_cyc++;
      if (o_busy && !o_tx_valid) gap_cyc++;
      step();
      if (toggle) tx_ready = ~tx_ready;
    end
    check("done_reached", {31'b0, o_done}, 1);
  endtask

  // Monitor: scoreboard pop on accepted beats, handshake hold rules, enable count.
  always @(negedge clk) begin
    if (o_gen_enable) enb_cnt++;
    if (rst_n && o_tx_valid && tx_ready) begin
      check("gen_enable_on_beat", {31'b0, o_gen_enable}, 1);
      if (exp_q.size() == 0) check("beat_expected", 32'(exp_q.size()), 1);
      else check("tx_last", {31'b0, o_tx_last}, {31'b0, exp_q.pop_front()});
    end
    if (rst_n && hold_prev) begin
      check("valid_held", {31'b0, o_tx_valid}, 1);
      check("last_stable", {31'b0, o_tx_last}, {31'b0, last_prev});
    end
    hold_prev = rst_n && o_tx_valid && !tx_ready;
    last_prev = o_tx_last;
  end

  initial begin
    int vc;
    int gc;
    int e0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
    burst_len = '0; num_bursts = '0; gap = '0;

    // Reset values
    step(); step();
    check("rst_valid", {31'b0, o_tx_valid}, 0);
    check("rst_last", {31'b0, o_tx_last}, 0);
    check("rst_enable", {31'b0, o_gen_enable}, 0);
    check("rst_busy", {31'b0, o_busy}, 0);
    check("rst_done", {31'b0, o_done}, 0);
    check("rst_beats", 32'(o_beat_count), 0);
    check("rst_bursts", 32'(o_burst_count), 0);
    check("rst_state", 32'(o_dbg_state), 0);
    rst_n = 1'b1;
    step();

    // Single burst len=4 num=1 gap=0, ready high
    push_bursts(4, 1);
    e0 = enb_cnt;
    start_run(4, 1, 0);
    check("t1_start_valid", {31'b0, o_tx_valid}, 1);
    check("t1_start_busy", {31'b0, o_busy}, 1);
    run_until_done(1'b0, 50, vc, gc);
    check("t1_valid_cycles", 32'(vc), 4);
    check("t1_enables", 32'(enb_cnt - e0), 4);
    check("t1_beats", 32'(o_beat_count), 4);
    check("t1_bursts", 32'(o_burst_count), 1);
    check("t1_busy_in_done", {31'b0, o_busy}, 1);
    step();
    check("t1_idle_busy", {31'b0, o_busy}, 0);
    check("t1_done_pulse", {31'b0, o_done}, 0);
    check("t1_queue_empty", 32'(exp_q.size()), 0);

    // Back-pressure len=3 num=2 gap=2, ready toggling
    push_bursts(3, 2);
    e0 = enb_cnt;
    start_run(3, 2, 2);
    run_until_done(1'b1, 100, vc, gc);
    tx_ready = 1'b1;
    check("t2_gap_cycles", 32'(gc), 2);
    check("t2_enables", 32'(enb_cnt - e0), 6);
    check("t2_beats", 32'(o_beat_count), 6);
    check("t2_bursts", 32'(o_burst_count), 2);
    step();
    check("t2_queue_empty", 32'(exp_q.size()), 0);

    // Continuous len=2 gap=0; abort coincides with a last beat
    push_bursts(2, 3);
    start_run(2, 0, 0);
    gc = 0;
    for (int i = 0; i < 5; i++) begin
      if (!o_tx_valid) gc++;
      step();
    end
    check("t3_no_bubble", 32'(gc), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t3_done", {31'b0, o_done}, 1);
    check("t3_bursts", 32'(o_burst_count), 3);
    check("t3_beats", 32'(o_beat_count), 6);
    step();
    check("t3_idle", {31'b0, o_busy}, 0);
    check("t3_queue_empty", 32'(exp_q.size()), 0);

    // Abort during GAP (gap=5)
    push_bursts(2, 1);
    start_run(2, 0, 5);
    step(); step();
    check("t4_in_gap_valid", {31'b0, o_tx_valid}, 0);
    check("t4_in_gap_busy", {31'b0, o_busy}, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_done", {31'b0, o_done}, 1);
    check("t4_bursts", 32'(o_burst_count), 1);
    step();
    check("t4_idle", {31'b0, o_busy}, 0);
    step(); step();
    check("t4_no_valid", {31'b0, o_tx_valid}, 0);

    // Zero-length start is ignored
    start_run(0, 1, 0);
    check("t5_busy", {31'b0, o_busy}, 0);
    step();
    check("t5_done", {31'b0, o_done}, 0);
    check("t5_bursts_kept", 32'(o_burst_count), 1);

    // Start while busy is ignored
    push_bursts(3, 1);
    start_run(3, 1, 0);
    burst_len = LW'(5); num_bursts = CW'(3); start = 1'b1;
    step();
    start = 1'b0;
    run_until_done(1'b0, 50, vc, gc);
    check("t6_beats", 32'(o_beat_count), 3);
    check("t6_bursts", 32'(o_burst_count), 1);
    step();
    check("t6_idle", {31'b0, o_busy}, 0);
    check("t6_queue_empty", 32'(exp_q.size()), 0);

    // Burst counter wrap with CNT_WIDTH=2: 5 bursts -> 1
    push_bursts(2, 5);
    start_run(2, 0, 0);
    for (int i = 0; i < 100 && o_beat_count != 8; i++) step();
    check("t7_reach8", 32'(o_beat_count), 8);
    check("t7_wrapped0", 32'(o_burst_count), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    run_until_done(1'b0, 50, vc, gc);
    check("t7_bursts", 32'(o_burst_count), 1);
    check("t7_beats", 32'(o_beat_count), 10);
    step();
    check("t7_queue_empty", 32'(exp_q.size()), 0);

    // Reset mid-burst, then a clean run
    push_bursts(4, 1);
    start_run(4, 1, 0);
    step();
    check("t8_valid_before", {31'b0, o_tx_valid}, 1);
    rst_n = 1'b0;
    step();
    check("t8_valid", {31'b0, o_tx_valid}, 0);
    check("t8_last", {31'b0, o_tx_last}, 0);
    check("t8_busy", {31'b0, o_busy}, 0);
    check("t8_done", {31'b0, o_done}, 0);
    check("t8_beats", 32'(o_beat_count), 0);
    check("t8_bursts", 32'(o_burst_count), 0);
    exp_q.delete();
    rst_n = 1'b1;
    step();
    push_bursts(3, 1);
    start_run(3, 1, 0);
    run_until_done(1'b0, 50, vc, gc);
    check("t8_re_beats", 32'(o_beat_count), 3);
    check("t8_re_bursts", 32'(o_burst_count), 1);
    step();
    check("t8_queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
